// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM encoding and PC step.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int          XLEN_DEF = 64;
  localparam int unsigned PC_INC   = 4;

endpackage

// File: rtl/pc_target_adder.sv
// Branch target generation: br_pc + (br_imm << 1), wrapping, plus a misalignment flag.
module pc_target_adder #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] w_imm_bytes;

  // Immediate arrives in halfword units; shifting out the top bit gives mod 2^XLEN wrap.
  assign w_imm_bytes = {br_imm[XLEN-2:0], 1'b0};
  assign target      = br_pc + w_imm_bytes;
  assign misaligned  = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// PC owner for the 5-stage core: hold, sequential step, or EX-resolved redirect,
// with wrong-path squash and a sticky halt on misaligned targets.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_imm,
  output logic [XLEN-1:0]  pc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt
);

  state_t           r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_misalign;
  logic [CNT_W-1:0] r_taken_cnt;

  logic [XLEN-1:0]  w_target;
  logic             w_misaligned;
  logic             w_redirect;

  pc_target_adder #(
    .XLEN(XLEN)
  ) u_target (
    .br_pc      (br_pc),
    .br_imm     (br_imm),
    .target     (w_target),
    .misaligned (w_misaligned)
  );

  assign w_redirect = br_valid & br_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_misalign  <= 1'b0;
      r_taken_cnt <= '0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          // A resolved EX branch outranks the load-use stall.
          if (w_redirect && w_misaligned) begin
            r_state    <= ST_HALT;
            r_misalign <= 1'b1;
          end else if (w_redirect) begin
            r_pc <= w_target;
            if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
          end else if (!stall) begin
            r_pc <= r_pc + XLEN'(PC_INC);
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  // Squash is combinational so IF/ID and ID/EX clear on the same edge pc loads the target.
  assign flush       = (r_state == ST_RUN) & w_redirect;
  assign fetch_valid = (r_state == ST_RUN);
  assign misalign    = r_misalign;
  assign pc          = r_pc;
  assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with RESET_PC=0x100 and a 2-bit taken counter.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [63:0] br_pc;
  logic [63:0] br_imm;
  logic [63:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        misalign;
  logic [1:0]  taken_cnt;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .XLEN     (64),
    .RESET_PC (64'h100),
    .CNT_W    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_pc       (br_pc),
    .br_imm      (br_imm),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .misalign    (misalign),
    .taken_cnt   (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_pc = '0; br_imm = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    br_valid = 1'b1; br_taken = 1'b1; br_pc = 64'h200; br_imm = 64'h8;
    #1;
    checks++; if (pc !== 64'h100) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 64'h100); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b want 0", fetch_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", misalign); end
    checks++; if (taken_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", taken_cnt); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #1;
    checks++; if (fetch_valid !== 1'b0 || pc !== 64'h100) begin errors++; $display("FAIL boot_cycle got fv=%b pc=%h want fv=0 pc=100", fetch_valid, pc); end
    tick();
    checks++; if (fetch_valid !== 1'b1 || pc !== 64'h100) begin errors++; $display("FAIL first_fetch got fv=%b pc=%h want fv=1 pc=100", fetch_valid, pc); end
    tick();
    checks++; if (fetch_valid !== 1'b1 || pc !== 64'h104) begin errors++; $display("FAIL seq1 got fv=%b pc=%h want fv=1 pc=104", fetch_valid, pc); end
    tick();
    checks++; if (fetch_valid !== 1'b1 || pc !== 64'h108) begin errors++; $display("FAIL seq2 got fv=%b pc=%h want fv=1 pc=108", fetch_valid, pc); end
  endtask

  task automatic test_branch();
    do_reset();
    br_pc = 64'h200; br_imm = 64'h8; br_valid = 1'b1; br_taken = 1'b1;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL br_flush got %b want 1", flush); end
    tick();
    clear_inputs();
    #1;
    checks++; if (pc !== 64'h210) begin errors++; $display("FAIL br_target got %h want %h", pc, 64'h210); end
    checks++; if (taken_cnt !== 2'd1) begin errors++; $display("FAIL br_cnt got %0d want 1", taken_cnt); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_flush_clr got %b want 0", flush); end
    br_pc = 64'h500; br_imm = 64'h8; br_valid = 1'b1; br_taken = 1'b0;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nt_flush got %b want 0", flush); end
    tick();
    checks++; if (pc !== 64'h214) begin errors++; $display("FAIL nt_pc got %h want %h", pc, 64'h214); end
    br_valid = 1'b0; br_taken = 1'b1;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL novld_flush got %b want 0", flush); end
    tick();
    checks++; if (pc !== 64'h218 || taken_cnt !== 2'd1) begin errors++; $display("FAIL novld_pc got pc=%h cnt=%0d want pc=218 cnt=1", pc, taken_cnt); end
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    repeat (8) tick();
    checks++; if (pc !== 64'h120) begin errors++; $display("FAIL stall_pre got %h want %h", pc, 64'h120); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 64'h120 || flush !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got pc=%h flush=%b want pc=120 flush=0", i, pc, flush); end
    end
    br_pc = 64'h120; br_imm = 64'hFFFF_FFFF_FFFF_FFF0; br_valid = 1'b1; br_taken = 1'b1;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_br_flush got %b want 1", flush); end
    tick();
    checks++; if (pc !== 64'h100 || taken_cnt !== 2'd1) begin errors++; $display("FAIL stall_br got pc=%h cnt=%0d want pc=100 cnt=1", pc, taken_cnt); end
    clear_inputs();
  endtask

  task automatic test_misalign();
    do_reset();
    br_pc = 64'h100; br_imm = 64'h100; br_valid = 1'b1; br_taken = 1'b1;
    tick();
    checks++; if (pc !== 64'h300) begin errors++; $display("FAIL mis_setup got %h want %h", pc, 64'h300); end
    br_pc = 64'h300; br_imm = 64'h1;
    #1;
    checks++; if (flush !== 1'b1 || misalign !== 1'b0) begin errors++; $display("FAIL mis_flush got flush=%b mis=%b want flush=1 mis=0", flush, misalign); end
    tick();
    checks++; if (pc !== 64'h300) begin errors++; $display("FAIL mis_pc got %h want %h", pc, 64'h300); end
    checks++; if (misalign !== 1'b1 || fetch_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL mis_halt got mis=%b fv=%b flush=%b want 1 0 0", misalign, fetch_valid, flush); end
    br_pc = 64'h400; br_imm = 64'h0;
    repeat (3) tick();
    checks++; if (pc !== 64'h300 || taken_cnt !== 2'd1 || misalign !== 1'b1) begin errors++; $display("FAIL halt_frozen got pc=%h cnt=%0d mis=%b want pc=300 cnt=1 mis=1", pc, taken_cnt, misalign); end
    reset = 1'b1;
    #1;
    checks++; if (misalign !== 1'b0 || pc !== 64'h100 || fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_reset got mis=%b pc=%h fv=%b want 0 100 0", misalign, pc, fetch_valid); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    br_pc = 64'h0; br_imm = 64'hFFFF_FFFF_FFFF_FFFE; br_valid = 1'b1; br_taken = 1'b1;
    tick();
    clear_inputs();
    checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h want %h", pc, 64'hFFFF_FFFF_FFFF_FFFC); end
    tick();
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL wrap_inc got %h want %h", pc, 64'h0); end
    br_pc = 64'hFFFF_FFFF_FFFF_FFF0; br_imm = 64'h10; br_valid = 1'b1; br_taken = 1'b1;
    tick();
    clear_inputs();
    checks++; if (pc !== 64'h10 || misalign !== 1'b0) begin errors++; $display("FAIL wrap_target got pc=%h mis=%b want pc=10 mis=0", pc, misalign); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] base;
    logic [1:0]  exp_cnt;
    do_reset();
    br_valid = 1'b1; br_taken = 1'b1; br_imm = 64'h4;
    for (int k = 1; k <= 5; k++) begin
      base = 64'h1000 * k;
      br_pc = base;
      exp_cnt = (k >= 3) ? 2'd3 : 2'(k);
      tick();
      checks++; if (pc !== base + 64'h8 || taken_cnt !== exp_cnt) begin errors++; $display("FAIL b2b%0d got pc=%h cnt=%0d want pc=%h cnt=%0d", k, pc, taken_cnt, base + 64'h8, exp_cnt); end
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    br_pc = 64'h700; br_imm = 64'h40; br_valid = 1'b1; br_taken = 1'b1;
    tick();
    checks++; if (pc !== 64'h780 || taken_cnt !== 2'd1) begin errors++; $display("FAIL ar_setup got pc=%h cnt=%0d want pc=780 cnt=1", pc, taken_cnt); end
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL ar_flush_pre got %b want 1", flush); end
    reset = 1'b1;
    #1;
    checks++; if (pc !== 64'h100 || fetch_valid !== 1'b0 || flush !== 1'b0 || taken_cnt !== 2'd0) begin errors++; $display("FAIL async_reset got pc=%h fv=%b flush=%b cnt=%0d want 100 0 0 0", pc, fetch_valid, flush, taken_cnt); end
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
